axi_rd_arbiter: RTL and testbench

- Shares the single AXI read channel of the core between instruction fetch (requester 0) and data load (requester 1).
- Each requester uses a req/addr_ok/data_ok handshake; the AXI side is single-beat with exactly one outstanding transaction.
- Produces axi_block, which the EXE-stage pipeline register uses to hold while a data load is in flight.

---
 rtl/axi_rd_arbiter_if.sv | 49 ++++
 rtl/axi_rd_arbiter.sv | 98 +++++++++
 tb/tb_axi_rd_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - requester and AXI read-channel bundle for axi_rd_arbiter
interface axi_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic [ADDR_W-1:0] data_addr;
    logic [1:0]        data_size;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic              axi_block;

    modport master (
        input  inst_req, inst_addr, data_req, data_addr, data_size,
        input  arready, rid, rdata, rlast, rvalid,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output arid, araddr, arlen, arsize, arvalid, rready, axi_block
    );

    modport slave (
        output inst_req, inst_addr, data_req, data_addr, data_size,
        output arready, rid, rdata, rlast, rvalid,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  arid, araddr, arlen, arsize, arvalid, rready, axi_block
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - single-outstanding AXI read arbiter for inst fetch and data load
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; default is data-over-inst priority.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              resetn,
    axi_rd_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state;
    state_t            state_nx;
    logic              owner_q;    // 1 = data requester
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic              pick_inst;
    logic              pick_data;
    logic              grant_inst;
    logic              grant_data;
    logic              r_hit;

`ifdef AXI_RD_ARB_RR_EN
    logic last_q;   // 1 = data won the most recent grant

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= 1'b1;
        end else if (grant_inst || grant_data) begin
            last_q <= grant_data;
        end
    end

    always_comb begin
        pick_data = bus.data_req && (!bus.inst_req || !last_q);
        pick_inst = bus.inst_req && (!bus.data_req || last_q);
    end
`else
    always_comb begin
        pick_data = bus.data_req;
        pick_inst = bus.inst_req && !bus.data_req;
    end
`endif

    assign grant_inst = (state == IDLE) && pick_inst;
    assign grant_data = (state == IDLE) && pick_data;
    assign r_hit      = (state == DATA) && bus.rvalid && (bus.rid == ID_W'(owner_q));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_inst || grant_data) state_nx = ADDR;
            ADDR:    if (bus.arready) state_nx = DATA;
            DATA:    if (r_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= 3'd0;
        end else if (grant_inst || grant_data) begin
            owner_q <= grant_data;
            addr_q  <= grant_data ? bus.data_addr : bus.inst_addr;
            size_q  <= grant_data ? {1'b0, bus.data_size} : 3'd2;
        end
    end

    always_comb begin
        bus.inst_addr_ok = grant_inst;
        bus.data_addr_ok = grant_data;
        bus.inst_data_ok = r_hit && !owner_q;
        bus.data_data_ok = r_hit && owner_q;
        bus.inst_rdata   = (r_hit && !owner_q) ? bus.rdata : '0;
        bus.data_rdata   = (r_hit && owner_q) ? bus.rdata : '0;
        bus.arvalid      = (state == ADDR);
        bus.arid         = ID_W'(owner_q);
        bus.araddr       = addr_q;
        bus.arsize       = size_q;
        bus.arlen        = 8'd0;
        // Mismatched beats are still accepted so they cannot stall the channel.
        bus.rready       = (state == DATA);
        bus.axi_block    = ((state != IDLE) && owner_q && !(r_hit && owner_q)) ||
                           ((state == IDLE) && bus.data_req && !grant_data);
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Request-level model state: pending requests, their addresses, last winner.
    logic        pi = 1'b0;
    logic        pd = 1'b0;
    logic [31:0] ai = 32'd0;
    logic [31:0] ad = 32'd0;
    logic [1:0]  sz = 2'd0;
    logic        last_d = 1'b1;

    axi_rd_arbiter_if bus ();

    axi_rd_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick();
`ifdef AXI_RD_ARB_RR_EN
        if (pi && pd) return !last_d;
`endif
        return pd;
    endfunction

    task automatic raise_i();
        pi = 1'b1;
        ai = $urandom;
    endtask

    task automatic raise_d();
        pd = 1'b1;
        ad = $urandom;
        sz = 2'($urandom_range(0, 2));
    endtask

    task automatic drive_reqs();
        bus.inst_req  = pi;
        bus.inst_addr = ai;
        bus.data_req  = pd;
        bus.data_addr = ad;
        bus.data_size = sz;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive_reqs();
        @(negedge clk);
        chk1("idle_no_inst_addr_ok", bus.inst_addr_ok, 1'b0);
        chk1("idle_no_data_addr_ok", bus.data_addr_ok, 1'b0);
        chk1("idle_arvalid", bus.arvalid, 1'b0);
        chk1("idle_rready", bus.rready, 1'b0);
        chk1("idle_block", bus.axi_block, 1'b0);
        next_cycle();
    endtask

    // One full transaction from the IDLE grant to the matching R beat.
    task automatic txn(input int dly, input int nbad, input logic [31:0] beat,
                       input logic [31:0] bad_word, input logic ni, input logic nd);
        logic        w;
        logic [31:0] wa;
        logic [2:0]  ws;
        logic [3:0]  bid;
        drive_reqs();
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        w  = pick();
        wa = w ? ad : ai;
        ws = w ? {1'b0, sz} : 3'd2;
        @(negedge clk);
        chk1("grant_inst_addr_ok", bus.inst_addr_ok, !w);
        chk1("grant_data_addr_ok", bus.data_addr_ok, w);
        chk1("grant_block", bus.axi_block, pd && !w);
        chk1("grant_no_data_ok", bus.inst_data_ok || bus.data_data_ok, 1'b0);
        next_cycle();
        last_d = w;
        if (w) pd = 1'b0;
        else   pi = 1'b0;
        if (ni && !pi) raise_i();
        if (nd && !pd) raise_d();
        drive_reqs();
        for (int c = 0; c <= dly; c++) begin
            bus.arready = (c == dly);
            @(negedge clk);
            chk1("addr_arvalid", bus.arvalid, 1'b1);
            chk32("addr_araddr", bus.araddr, wa);
            chk32("addr_arid", 32'(bus.arid), 32'(w));
            chk32("addr_arsize", 32'(bus.arsize), 32'(ws));
            chk32("addr_arlen", 32'(bus.arlen), 32'd0);
            chk1("addr_rready", bus.rready, 1'b0);
            chk1("addr_no_addr_ok", bus.inst_addr_ok || bus.data_addr_ok, 1'b0);
            chk1("addr_no_data_ok", bus.inst_data_ok || bus.data_data_ok, 1'b0);
            chk1("addr_block", bus.axi_block, w);
            next_cycle();
        end
        bus.arready = 1'b0;
        for (int c = 0; c <= nbad; c++) begin
            bid = (c == 0) ? {3'b000, !w} : 4'($urandom_range(2, 15));
            bus.rvalid = 1'b1;
            bus.rlast  = 1'b1;
            bus.rid    = (c == nbad) ? {3'b000, w} : bid;
            bus.rdata  = (c == nbad) ? beat : ((c == 0) ? bad_word : $urandom);
            @(negedge clk);
            chk1("data_rready", bus.rready, 1'b1);
            chk1("data_arvalid", bus.arvalid, 1'b0);
            chk1("data_no_addr_ok", bus.inst_addr_ok || bus.data_addr_ok, 1'b0);
            if (c == nbad) begin
                chk1("hit_inst_data_ok", bus.inst_data_ok, !w);
                chk1("hit_data_data_ok", bus.data_data_ok, w);
                chk32("hit_inst_rdata", bus.inst_rdata, w ? 32'd0 : beat);
                chk32("hit_data_rdata", bus.data_rdata, w ? beat : 32'd0);
                chk1("hit_block", bus.axi_block, 1'b0);
            end else begin
                chk1("drop_no_data_ok", bus.inst_data_ok || bus.data_data_ok, 1'b0);
                chk32("drop_inst_rdata", bus.inst_rdata, 32'd0);
                chk32("drop_data_rdata", bus.data_rdata, 32'd0);
                chk1("drop_block", bus.axi_block, w);
            end
            next_cycle();
        end
        bus.rvalid = 1'b0;
    endtask

    initial begin
        bus.inst_req = 1'b0; bus.inst_addr = '0;
        bus.data_req = 1'b0; bus.data_addr = '0; bus.data_size = 2'd0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rid = '0;
        bus.rdata = '0; bus.rlast = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_arvalid", bus.arvalid, 1'b0);
        chk1("rst_rready", bus.rready, 1'b0);
        chk1("rst_block", bus.axi_block, 1'b0);
        chk32("rst_araddr", bus.araddr, 32'd0);
        next_cycle();
        resetn = 1'b1;
        idle_cycle();

        // Single instruction read at minimum latency, then an empty IDLE cycle
        pi = 1'b1; ai = 32'hBFC0_0000;
        txn(0, 0, 32'h3C08_BFAF, 32'd0, 1'b0, 1'b0);
        idle_cycle();

        // Simultaneous requests, then alternation while both keep requesting
        pi = 1'b1; ai = 32'hBFC0_0010;
        pd = 1'b1; ad = 32'h8000_1002; sz = 2'd1;
        txn(0, 0, 32'hA5A5_0001, 32'd0, 1'b0, 1'b0);
        txn(0, 0, 32'hA5A5_0002, 32'd0, 1'b0, 1'b0);
        pi = 1'b1; pd = 1'b1;
        repeat (4) txn(0, 0, $urandom, 32'd0, 1'b1, 1'b1);
        pi = 1'b0; pd = 1'b0;

        // arready held low for five cycles
        raise_d();
        txn(5, 0, 32'h0BAD_F00D, 32'd0, 1'b0, 1'b0);

        // Mismatched rid beat dropped before the owner's beat
        pd = 1'b1; ad = 32'h8000_2000; sz = 2'd2;
        txn(0, 1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            if (!pi && !pd) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                if ($urandom_range(0, 1) == 1) raise_i();
                if ($urandom_range(0, 1) == 1) raise_d();
                if (!pi && !pd) raise_d();
            end
            txn($urandom_range(0, 3), $urandom_range(0, 2), $urandom, $urandom,
                1'($urandom), 1'($urandom));
        end

        // Asynchronous reset while a data load is in DATA
        pi = 1'b0; pd = 1'b0;
        next_cycle();
        pd = 1'b1; ad = 32'h8000_3000; sz = 2'd2;
        drive_reqs();
        next_cycle();
        pd = 1'b0;
        drive_reqs();
        bus.arready = 1'b1;
        next_cycle();
        bus.arready = 1'b0;
        #1;
        chk1("pre_rst_rready", bus.rready, 1'b1);
        chk1("pre_rst_block", bus.axi_block, 1'b1);
        resetn = 1'b0;
        #1;
        chk1("async_rst_arvalid", bus.arvalid, 1'b0);
        chk1("async_rst_rready", bus.rready, 1'b0);
        chk1("async_rst_block", bus.axi_block, 1'b0);
        bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk1("in_rst_data_ok", bus.data_data_ok, 1'b0);
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        chk1("post_rst_stale_data_ok", bus.data_data_ok, 1'b0);
        chk1("post_rst_rready", bus.rready, 1'b0);
        next_cycle();
        bus.rvalid = 1'b0;
        last_d = 1'b1;
        pi = 1'b1; ai = 32'hBFC0_0100;
        txn(1, 0, 32'h2400_0001, 32'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
